// File: rtl/gen_bank_ctrl.sv
// rtl/gen_bank_ctrl.sv - multi-bank generation buffer controller with frame-synchronous display commit
// Optional feature macro: GEN_COUNT_EN (gen_count register; tied to 0 when undefined)
module gen_bank_ctrl #(
  parameter int X_SIZE    = 1280,
  parameter int Y_SIZE    = 720,
  parameter int Y_WIDTH   = 10,
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pause,
  input  logic                           step,
  input  logic                           frame_end,
  output logic                           gen_start,
  input  logic                           gen_done,
  input  logic [Y_WIDTH-1:0]             line_buffer_fetch_addr,
  output logic [X_SIZE-1:0]              line_buffer_fetch_mem,
  input  logic [Y_WIDTH-1:0]             parallel_next_state_write_addr,
  input  logic [X_SIZE-1:0]              parallel_next_state_result,
  input  logic                           parallel_next_state_write_en,
  input  logic [Y_WIDTH-1:0]             video_out_row_addr,
  output logic [X_SIZE-1:0]              video_out_row_data,
  output logic [NUM_BANKS*Y_WIDTH-1:0]   bram_addra,
  output logic [NUM_BANKS*Y_WIDTH-1:0]   bram_addrb,
  output logic [NUM_BANKS*X_SIZE-1:0]    bram_dina,
  output logic [NUM_BANKS-1:0]           bram_wea,
  input  logic [NUM_BANKS*X_SIZE-1:0]    bram_douta,
  input  logic [NUM_BANKS*X_SIZE-1:0]    bram_doutb,
  output logic [BANK_W-1:0]              read_bank,
  output logic [BANK_W-1:0]              write_bank,
  output logic [BANK_W-1:0]              display_bank,
  output logic                           busy,
  output logic [31:0]                    gen_count
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  generate
    if (NUM_BANKS < 2 || NUM_BANKS > 4) begin : g_bad_num_banks
      $error("gen_bank_ctrl: NUM_BANKS must be 2..4");
    end
    if ((1 << BANK_W) < NUM_BANKS) begin : g_bad_bank_w
      $error("gen_bank_ctrl: BANK_W too narrow for NUM_BANKS");
    end
    if (Y_SIZE > (1 << Y_WIDTH)) begin : g_bad_y_width
      $error("gen_bank_ctrl: Y_WIDTH too narrow for Y_SIZE");
    end
  endgenerate

  logic [0:0]        state;
  logic              free;
  logic              start_cond;
  logic              commit;
  logic [BANK_W-1:0] cand;

  // Walk k downward so the smallest k that avoids display_bank wins.
  always_comb begin
    free       = 1'b0;
    cand       = '0;
    write_bank = BANK_W'((int'(read_bank) + 1) % NUM_BANKS);
    for (int k = NUM_BANKS - 1; k >= 1; k--) begin
      cand = BANK_W'((int'(read_bank) + k) % NUM_BANKS);
      if (cand != display_bank) begin
        write_bank = cand;
        free       = 1'b1;
      end
    end
  end

  assign start_cond = (state == S_IDLE) && free && (!pause || step);
  assign commit     = (state == S_RUN) && gen_done;
  assign gen_start  = rst_n && start_cond;
  assign busy       = (state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      read_bank    <= '0;
      display_bank <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_cond) state <= S_RUN;
        S_RUN: begin
          if (gen_done) begin
            read_bank <= write_bank;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // A commit in the same cycle hands the freshly written bank straight to the display.
      if (frame_end) display_bank <= commit ? write_bank : read_bank;
    end
  end

`ifdef GEN_COUNT_EN
  logic [31:0] count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count_q <= '0;
    else if (commit) count_q <= count_q + 32'd1;
  end
  assign gen_count = count_q;
`else
  assign gen_count = '0;
`endif

  always_comb begin
    bram_addra            = '0;
    bram_addrb            = '0;
    bram_dina             = '0;
    bram_wea              = '0;
    line_buffer_fetch_mem = '0;
    video_out_row_data    = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bram_addra[b*Y_WIDTH +: Y_WIDTH] = (BANK_W'(b) == write_bank) ?
                                         parallel_next_state_write_addr : line_buffer_fetch_addr;
      bram_addrb[b*Y_WIDTH +: Y_WIDTH] = video_out_row_addr;
      bram_dina[b*X_SIZE +: X_SIZE]    = parallel_next_state_result;
      bram_wea[b] = busy && parallel_next_state_write_en && (BANK_W'(b) == write_bank);
      if (BANK_W'(b) == read_bank)    line_buffer_fetch_mem = bram_douta[b*X_SIZE +: X_SIZE];
      if (BANK_W'(b) == display_bank) video_out_row_data    = bram_doutb[b*X_SIZE +: X_SIZE];
    end
  end

endmodule

// File: tb/tb_gen_bank_ctrl.sv
// tb/tb_gen_bank_ctrl.sv - checks gen_bank_ctrl (2- and 3-bank builds) against a behavioural bank-rotation model
module tb_gen_bank_ctrl;
  localparam int X  = 8;
  localparam int YW = 4;
  localparam int YS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pause = 1'b1, step = 1'b0, frame_end = 1'b0, gen_done = 1'b0, we = 1'b0;
  logic [YW-1:0] fetch_addr = '0, wr_addr = '0, vid_addr = '0;
  logic [X-1:0]  wr_data = '0;
  logic [2*X-1:0] douta_a = '0, doutb_a = '0;
  logic [3*X-1:0] douta_b = '0, doutb_b = '0;

  logic gs_a, busy_a, gs_b, busy_b;
  logic [X-1:0] fm_a, vd_a, fm_b, vd_b;
  logic [2*YW-1:0] addra_a, addrb_a;
  logic [3*YW-1:0] addra_b, addrb_b;
  logic [2*X-1:0] dina_a;
  logic [3*X-1:0] dina_b;
  logic [1:0] wea_a;
  logic [2:0] wea_b;
  logic [1:0] rb_a, wb_a, db_a, rb_b, wb_b, db_b;
  logic [31:0] cnt_a, cnt_b;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gen_bank_ctrl #(.X_SIZE(X), .Y_SIZE(YS), .Y_WIDTH(YW), .NUM_BANKS(2), .BANK_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .pause(pause), .step(step), .frame_end(frame_end),
    .gen_start(gs_a), .gen_done(gen_done),
    .line_buffer_fetch_addr(fetch_addr), .line_buffer_fetch_mem(fm_a),
    .parallel_next_state_write_addr(wr_addr), .parallel_next_state_result(wr_data),
    .parallel_next_state_write_en(we),
    .video_out_row_addr(vid_addr), .video_out_row_data(vd_a),
    .bram_addra(addra_a), .bram_addrb(addrb_a), .bram_dina(dina_a), .bram_wea(wea_a),
    .bram_douta(douta_a), .bram_doutb(doutb_a),
    .read_bank(rb_a), .write_bank(wb_a), .display_bank(db_a), .busy(busy_a), .gen_count(cnt_a));

  gen_bank_ctrl #(.X_SIZE(X), .Y_SIZE(YS), .Y_WIDTH(YW), .NUM_BANKS(3), .BANK_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .pause(pause), .step(step), .frame_end(frame_end),
    .gen_start(gs_b), .gen_done(gen_done),
    .line_buffer_fetch_addr(fetch_addr), .line_buffer_fetch_mem(fm_b),
    .parallel_next_state_write_addr(wr_addr), .parallel_next_state_result(wr_data),
    .parallel_next_state_write_en(we),
    .video_out_row_addr(vid_addr), .video_out_row_data(vd_b),
    .bram_addra(addra_b), .bram_addrb(addrb_b), .bram_dina(dina_b), .bram_wea(wea_b),
    .bram_douta(douta_b), .bram_doutb(doutb_b),
    .read_bank(rb_b), .write_bank(wb_b), .display_bank(db_b), .busy(busy_b), .gen_count(cnt_b));

  // Behavioural model: per instance, whether a generation is running, which bank is read, which is shown.
  int nb[2] = '{2, 3};
  bit m_run[2] = '{0, 0};
  int m_rd[2] = '{0, 0};
  int m_disp[2] = '{0, 0};
  logic [31:0] m_cnt[2] = '{32'd0, 32'd0};

  function automatic int free_bank(int n, int rd, int dp);
    for (int k = 1; k < n; k++)
      if ((rd + k) % n != dp) return (rd + k) % n;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 0; m_rd[i] = 0; m_disp[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int w, new_rd;
        bit done_now;
        w        = free_bank(nb[i], m_rd[i], m_disp[i]);
        done_now = m_run[i] && gen_done;
        new_rd   = done_now ? w : m_rd[i];
        if (frame_end) m_disp[i] = new_rd;
        m_rd[i] = new_rd;
        if (done_now) begin
          m_run[i] = 0;
          m_cnt[i] = m_cnt[i] + 32'd1;
        end else if (!m_run[i] && w >= 0 && (!pause || step)) begin
          m_run[i] = 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [63:0] gs, input logic [63:0] bz,
                          input logic [63:0] rb, input logic [63:0] db, input logic [63:0] wbk,
                          input logic [63:0] wea, input logic [63:0] aa, input logic [63:0] ab,
                          input logic [63:0] din, input logic [63:0] fm, input logic [63:0] vd,
                          input logic [63:0] cnt, input logic [63:0] da, input logic [63:0] dbo);
    int n, w;
    logic [63:0] e_wea, e_aa, e_ab, e_din;
    string p;
    n = nb[i];
    w = free_bank(n, m_rd[i], m_disp[i]);
    p = $sformatf("n%0d", n);
    chk({p, ".gen_start"}, gs, 64'(rst_n && !m_run[i] && w >= 0 && (!pause || step)));
    chk({p, ".busy"}, bz, 64'(m_run[i]));
    chk({p, ".read_bank"}, rb, 64'(m_rd[i]));
    chk({p, ".display_bank"}, db, 64'(m_disp[i]));
    e_wea = 0; e_aa = 0; e_ab = 0; e_din = 0;
    for (int b = 0; b < n; b++) begin
      e_aa  = e_aa | (64'((b == w) ? wr_addr : fetch_addr) << (b * YW));
      e_ab  = e_ab | (64'(vid_addr) << (b * YW));
      e_din = e_din | (64'(wr_data) << (b * X));
    end
    if (m_run[i] && we && w >= 0) e_wea = 64'd1 << w;
    chk({p, ".wea"}, wea, e_wea);
    if (w >= 0) begin
      chk({p, ".write_bank"}, wbk, 64'(w));
      chk({p, ".addra"}, aa, e_aa);
    end
    chk({p, ".addrb"}, ab, e_ab);
    chk({p, ".dina"}, din, e_din);
    chk({p, ".fetch_mem"}, fm, (da >> (m_rd[i] * X)) & 64'hFF);
    chk({p, ".video_data"}, vd, (dbo >> (m_disp[i] * X)) & 64'hFF);
`ifdef GEN_COUNT_EN
    chk({p, ".gen_count"}, cnt, 64'(m_cnt[i]));
`else
    chk({p, ".gen_count"}, cnt, 64'd0);
`endif
  endtask

  always @(negedge clk) begin
    cmp_inst(0, 64'(gs_a), 64'(busy_a), 64'(rb_a), 64'(db_a), 64'(wb_a), 64'(wea_a), 64'(addra_a),
             64'(addrb_a), 64'(dina_a), 64'(fm_a), 64'(vd_a), 64'(cnt_a), 64'(douta_a), 64'(doutb_a));
    cmp_inst(1, 64'(gs_b), 64'(busy_b), 64'(rb_b), 64'(db_b), 64'(wb_b), 64'(wea_b), 64'(addra_b),
             64'(addrb_b), 64'(dina_b), 64'(fm_b), 64'(vd_b), 64'(cnt_b), 64'(douta_b), 64'(doutb_b));
  end

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    pause = 1'b0;
    #1;
    chk("rst.gen_start", 64'(gs_a), 64'd0);
    chk("rst.busy", 64'(busy_a), 64'd0);
    chk("rst.wea", 64'({wea_b, wea_a}), 64'd0);
    chk("rst.banks", 64'({rb_a, db_a, wb_a}), 64'b00_00_01);
    rst_n = 1'b1;
    #1;
    chk("first.gen_start_a", 64'(gs_a), 64'd1);
    chk("first.gen_start_b", 64'(gs_b), 64'd1);
    chk("first.write_bank_a", 64'(wb_a), 64'd1);

    we = 1'b1; wr_addr = 4'd5;
    step_cyc(); #1;
    chk("run.busy_a", 64'(busy_a), 64'd1);
    chk("run.wea_a", 64'(wea_a), 64'b10);
    chk("run.wea_b", 64'(wea_b), 64'b010);

    gen_done = 1'b1; we = 1'b0;
    step_cyc(); gen_done = 1'b0; #1;
    chk("c1.read_a", 64'(rb_a), 64'd1);
    chk("c1.disp_a", 64'(db_a), 64'd0);
    chk("c1.gen_start_a", 64'(gs_a), 64'd0);
    chk("c1.write_bank_b", 64'(wb_b), 64'd2);
    chk("c1.gen_start_b", 64'(gs_b), 64'd1);

    step_cyc(); step_cyc(); #1;
    chk("wait.gen_start_a", 64'(gs_a), 64'd0);
    chk("wait.busy_b", 64'(busy_b), 64'd1);

    gen_done = 1'b1;
    step_cyc(); gen_done = 1'b0; pause = 1'b1; #1;
    chk("c2.read_b", 64'(rb_b), 64'd2);
    chk("c2.disp_b", 64'(db_b), 64'd0);
    chk("c2.write_bank_b", 64'(wb_b), 64'd1);
    chk("c2.read_a_ignored", 64'(rb_a), 64'd1);

    frame_end = 1'b1;
    step_cyc(); frame_end = 1'b0; pause = 1'b0; #1;
    chk("fe.disp_a", 64'(db_a), 64'd1);
    chk("fe.write_bank_a", 64'(wb_a), 64'd0);
    chk("fe.gen_start_a", 64'(gs_a), 64'd1);
    chk("fe.disp_b", 64'(db_b), 64'd2);

    step_cyc();
    gen_done = 1'b1; frame_end = 1'b1;
    step_cyc(); gen_done = 1'b0; frame_end = 1'b0; pause = 1'b1; #1;
    chk("same.read_a", 64'(rb_a), 64'd0);
    chk("same.disp_a", 64'(db_a), 64'd0);
    chk("same.disp_b", 64'(db_b), 64'd0);

    chk("pause.gen_start_a", 64'(gs_a), 64'd0);
    step = 1'b1; #1;
    chk("step.gen_start_a", 64'(gs_a), 64'd1);
    step_cyc(); step = 1'b0; #1;
    chk("step.busy_a", 64'(busy_a), 64'd1);
    chk("step.no_restart", 64'(gs_a), 64'd0);
    step = 1'b1;
    step_cyc(); step = 1'b0;
    gen_done = 1'b1;
    step_cyc(); gen_done = 1'b0;
    step_cyc(); #1;
    chk("stepdrop.busy_b", 64'(busy_b), 64'd0);
    chk("stepdrop.read_a", 64'(rb_a), 64'd1);
`ifdef GEN_COUNT_EN
    chk("count_a", 64'(cnt_a), 64'd3);
    chk("count_b", 64'(cnt_b), 64'd4);
`else
    chk("count_a", 64'(cnt_a), 64'd0);
`endif
    we = 1'b1; wr_addr = 4'd3; #1;
    chk("idle.wea", 64'({wea_b, wea_a}), 64'd0);

    pause = 1'b0;
    step_cyc(); #1;
    chk("mid.busy_b", 64'(busy_b), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy_b", 64'(busy_b), 64'd0);
    chk("arst.read_b", 64'(rb_b), 64'd0);
    chk("arst.gen_start_b", 64'(gs_b), 64'd0);
    chk("arst.wea_b", 64'(wea_b), 64'd0);
    chk("arst.gen_count_b", 64'(cnt_b), 64'd0);
    step_cyc();
    rst_n = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      step_cyc();
      rst_n      = ($urandom_range(0, 599) != 0);
      pause      = ($urandom_range(0, 9) < 3);
      step       = ($urandom_range(0, 9) == 0);
      gen_done   = ($urandom_range(0, 6) == 0);
      frame_end  = ($urandom_range(0, 9) == 0);
      we         = $urandom_range(0, 1);
      fetch_addr = YW'($urandom_range(0, YS - 1));
      wr_addr    = YW'($urandom_range(0, YS - 1));
      vid_addr   = YW'($urandom_range(0, YS - 1));
      wr_data    = X'($urandom);
      douta_a    = (2*X)'($urandom);
      doutb_a    = (2*X)'($urandom);
      douta_b    = (3*X)'($urandom);
      doutb_b    = (3*X)'($urandom);
    end
    step_cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
